// File: rtl/xpmwrap_sdpram_bytewr_stream.sv
// ---------------------------------------------------------------------------
// xpmwrap_sdpram_bytewr_stream
//
// Purpose:
//   Single-clock simple-dual-port RAM with per-byte write enables. It wraps a
//   block-RAM core that behaves like xpm_memory_sdpram (common clock,
//   READ_LATENCY-deep read pipe) and adds streaming handshakes:
//     - a valid/ready write port,
//     - a valid/ready read-request port,
//     - a valid/ready read-response port, backed by a first-word-fall-through
//       FIFO. Reads are only accepted while there is guaranteed room for them.
//   A write and a read to the same word in the same cycle are merged byte by
//   byte: lanes being written return the new data and the others return the
//   old RAM contents.
//   A clear engine zero-fills the whole array after reset (CLEAR_ON_RESET=1)
//   and whenever clear_req is pulsed while running.
//
// Ports:
//   clk, rstn                    clock; asynchronous active-low reset
//   wr_valid/wr_ready            write handshake; wr_addr, wr_data, wr_be
//   rd_valid/rd_ready            read-request handshake; rd_addr
//   rsp_valid/rsp_ready          read-response handshake; rsp_data (in order)
//   clear_req                    one-cycle pulse that re-zeroes the array
//   init_done                    high while the block is in RUN
// ---------------------------------------------------------------------------
module xpmwrap_sdpram_bytewr_stream #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic                             rd_valid,
    output logic                             rd_ready,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    input  logic                             clear_req,
    output logic                             init_done
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LAT   = READ_LATENCY;
    localparam int FD    = READ_LATENCY + 1;      // response FIFO depth
    localparam int PW    = $clog2(FD);
    localparam int OW    = $clog2(FD + 1);

    localparam logic [OW-1:0]         OUT_MAX   = OW'(FD);
    localparam logic [PW-1:0]         PTR_LAST  = PW'(FD - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam state_t ST_EXIT = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    state_t                state_q, state_d;
    logic                  live_q, live_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [OW-1:0]         outstanding_q, outstanding_d;

    logic wr_fire;
    logic rd_fire;
    logic rsp_fire;
    logic collide;

    assign wr_fire = wr_valid & wr_ready;
    assign rd_fire = rd_valid & rd_ready;

    // The reset state of the FSM can already be RUN, so live_q keeps the
    // handshakes closed until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_EXIT;
            live_q        <= 1'b0;
            clr_addr_q    <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            live_q        <= live_d;
            clr_addr_q    <= clr_addr_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        live_d     = 1'b1;
        clr_addr_d = '0;
        case (state_q)
            ST_INIT: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == ADDR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (live_q && clear_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Wait until every accepted read has been handed out.
                if (outstanding_q == '0) begin
                    state_d = ST_INIT;
                end
            end
            default: state_d = ST_EXIT;
        endcase
    end

    // Output logic
    always_comb begin
        wr_ready  = 1'b0;
        rd_ready  = 1'b0;
        init_done = 1'b0;
        if (live_q && (state_q == ST_RUN)) begin
            wr_ready  = 1'b1;
            init_done = 1'b1;
            // A response leaving this cycle frees a slot for a new read.
            rd_ready  = (outstanding_q < OUT_MAX) || rsp_fire;
        end
    end

    // Reads in flight plus FIFO occupancy.
    assign outstanding_d = outstanding_q
                         + {{(OW-1){1'b0}}, rd_fire}
                         - {{(OW-1){1'b0}}, rsp_fire};

    // -----------------------------------------------------------------------
    // RAM core: port A writes (clear engine or user), port B reads
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [NB-1:0]         wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;

    always_comb begin
        if (state_q == ST_INIT) begin
            wea   = '1;
            addra = clr_addr_q;
            dina  = '0;
        end else begin
            wea   = wr_fire ? wr_be : '0;
            addra = wr_addr;
            dina  = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wea[b]) begin
                mem[addra][b*BYTE_WIDTH +: BYTE_WIDTH] <= dina[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Read data pipe. The port B read samples the array before the same-edge
    // write lands, so a colliding read sees the pre-write word; the written
    // lanes are patched in from the forward pipe at the end.
    logic [DATA_WIDTH-1:0] doutb_q    [LAT];
    logic [DATA_WIDTH-1:0] fwd_data_q [LAT];
    logic [NB-1:0]         fwd_be_q   [LAT];
    logic [NB-1:0]         fwd_be_d   [LAT];
    logic [LAT-1:0]        vld_q, vld_d;

    always_ff @(posedge clk) begin
        if (rd_fire) begin
            doutb_q[0]    <= mem[rd_addr];
            fwd_data_q[0] <= wr_data;
        end
        for (int k = 1; k < LAT; k++) begin
            doutb_q[k]    <= doutb_q[k-1];
            fwd_data_q[k] <= fwd_data_q[k-1];
        end
    end

    assign collide = wr_fire && rd_fire && (wr_addr == rd_addr);

    always_comb begin
        vld_d       = '0;
        fwd_be_d    = '{default: '0};
        vld_d[0]    = rd_fire;
        fwd_be_d[0] = collide ? wr_be : '0;
        for (int k = 1; k < LAT; k++) begin
            vld_d[k]    = vld_q[k-1];
            fwd_be_d[k] = fwd_be_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q    <= '0;
            fwd_be_q <= '{default: '0};
        end else begin
            vld_q    <= vld_d;
            fwd_be_q <= fwd_be_d;
        end
    end

    logic [DATA_WIDTH-1:0] merged;
    genvar gi;
    for (gi = 0; gi < NB; gi++) begin : g_merge
        assign merged[gi*BYTE_WIDTH +: BYTE_WIDTH] =
            fwd_be_q[LAT-1][gi] ? fwd_data_q[LAT-1][gi*BYTE_WIDTH +: BYTE_WIDTH]
                                : doutb_q[LAT-1][gi*BYTE_WIDTH +: BYTE_WIDTH];
    end

    // -----------------------------------------------------------------------
    // Response FIFO (first-word fall-through with empty bypass)
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fifo_mem [FD];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic                  fifo_empty;
    logic                  vld_last;
    logic                  push;
    logic                  pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign vld_last   = vld_q[LAT-1];
    assign fifo_empty = (fifo_cnt_q == '0);
    assign rsp_valid  = !fifo_empty || vld_last;
    assign rsp_fire   = rsp_valid && rsp_ready;
    // When the FIFO is empty and the consumer is ready, the word bypasses
    // the storage entirely; otherwise it is queued behind older responses.
    assign push       = vld_last && !(fifo_empty && rsp_ready);
    assign pop        = !fifo_empty && rsp_ready;

    // Data is forced to zero while invalid so nothing stale is presented.
    assign rsp_data   = !fifo_empty ? fifo_mem[rd_ptr_q]
                      : (vld_last ? merged : '0);

    always_comb begin
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q
                   + {{(OW-1){1'b0}}, push}
                   - {{(OW-1){1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= merged;
        end
    end

endmodule

// File: tb/tb_xpmwrap_sdpram_bytewr_stream.sv
// ---------------------------------------------------------------------------
// tb_xpmwrap_sdpram_bytewr_stream
//
// Directed bench for the byte-write streaming SDP RAM (default parameters:
// 64 words x 32 bits, 4 lanes, read latency 2). Inputs are driven and
// outputs sampled on the falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_xpmwrap_sdpram_bytewr_stream;

    logic        clk;
    logic        rstn;
    logic        wr_valid;
    logic        wr_ready;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_valid;
    logic        rd_ready;
    logic [5:0]  rd_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        clear_req;
    logic        init_done;

    int errors;
    int checks;

    xpmwrap_sdpram_bytewr_stream #(
        .ADDR_WIDTH    (6),
        .DATA_WIDTH    (32),
        .BYTE_WIDTH    (8),
        .READ_LATENCY  (2),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_addr  (rd_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .clear_req(clear_req),
        .init_done(init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        n = 0;
        while (!wr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!wr_ready) begin
            errors++;
            $display("FAIL write_timeout addr=%0d wr_ready got %b want 1", a, wr_ready);
        end
        $display("write addr=%0d data=%h be=%b", a, d, be);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d, output bit ok);
        int n;
        @(negedge clk);
        rd_valid  = 1'b1;
        rd_addr   = a;
        rsp_ready = 1'b1;
        n = 0;
        while (!rd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = rd_ready;
        @(negedge clk);
        rd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = ok && rsp_valid;
        d  = rsp_data;
        $display("read addr=%0d data=%h ok=%0d", a, d, ok);
    endtask

    task automatic issue_reads(input int base, input int cnt);
        int acc;
        int cyc;
        acc = 0;
        cyc = 0;
        @(negedge clk);
        while (acc < cnt && cyc < 50) begin
            rd_valid = 1'b1;
            rd_addr  = 6'(base + acc);
            if (rd_ready) acc++;
            @(negedge clk);
            cyc++;
        end
        rd_valid = 1'b0;
        checks++;
        if (acc != cnt) begin
            errors++;
            $display("FAIL issue_reads accepted got %0d want %0d", acc, cnt);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int cyc;
        rstn      = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_be     = '0;
        rd_valid  = 1'b0;
        rd_addr   = '0;
        rsp_ready = 1'b0;
        clear_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (wr_ready !== 1'b0)  begin errors++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
        checks++; if (rd_ready !== 1'b0)  begin errors++; $display("FAIL reset_rd_ready got %b want 0", rd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", init_done); end
        rstn = 1'b1;
        cyc = 0;
        while (!init_done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc != 64 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_latency got %0d cycles (init_done=%b) want 64", cyc, init_done);
        end
        $display("reset released, init_done after %0d cycles", cyc);
    endtask

    task automatic test_init_zero;
        logic [31:0] d;
        bit ok;
        for (int a = 0; a < 64; a++) begin
            do_read(6'(a), d, ok);
            checks++;
            if (!ok || d !== 32'h0) begin
                errors++;
                $display("FAIL init_zero addr=%0d got %h ok=%0d want 00000000", a, d, ok);
            end
        end
    endtask

    task automatic test_byte_write;
        logic [31:0] d;
        bit ok;
        do_write(6'd5, 32'hAABBCCDD, 4'b1111);
        do_write(6'd5, 32'h11223344, 4'b0101);
        do_read(6'd5, d, ok);
        checks++;
        if (!ok || d !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL byte_write got %h want aa22cc44", d);
        end
        do_write(6'd5, 32'hFFFFFFFF, 4'b0000);
        do_read(6'd5, d, ok);
        checks++;
        if (!ok || d !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL be_zero got %h want aa22cc44", d);
        end
    endtask

    task automatic test_collision;
        logic [31:0] d;
        bit ok;
        do_write(6'd9, 32'h01020304, 4'b1111);
        @(negedge clk);
        wr_valid  = 1'b1; wr_addr = 6'd9; wr_data = 32'hDEADBEEF; wr_be = 4'b1100;
        rd_valid  = 1'b1; rd_addr = 6'd9; rsp_ready = 1'b1;
        checks++;
        if (!(wr_ready && rd_ready)) begin
            errors++;
            $display("FAIL collision_ready got wr=%b rd=%b want 1 1", wr_ready, rd_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL collision_early got rsp_valid=%b want 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD0304) begin
            errors++;
            $display("FAIL collision_fwd got valid=%b data=%h want 1 dead0304", rsp_valid, rsp_data);
        end
        $display("collision addr=9 rsp=%h", rsp_data);
        do_read(6'd9, d, ok);
        checks++;
        if (!ok || d !== 32'hDEAD0304) begin
            errors++;
            $display("FAIL collision_after got %h want dead0304", d);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] first;
        int acc;
        int got;
        int n;
        for (int i = 0; i < 6; i++) begin
            do_write(6'(20 + i), 32'hA5000000 | 32'(20 + i), 4'hF);
        end
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rd_valid = 1'b1;
            rd_addr  = 6'(20 + acc);
            if (rd_ready) acc++;
        end
        @(negedge clk);
        rd_valid = 1'b0;
        checks++; if (acc != 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", acc); end
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL bp_rd_ready got %b want 0", rd_ready); end
        first = rsp_data;
        checks++;
        if (rsp_valid !== 1'b1 || first !== 32'hA5000014) begin
            errors++;
            $display("FAIL bp_head got valid=%b data=%h want 1 a5000014", rsp_valid, first);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== first) begin
            errors++;
            $display("FAIL bp_stable got valid=%b data=%h want 1 %h", rsp_valid, rsp_data, first);
        end
        rsp_ready = 1'b1;
        got = 0;
        n = 0;
        while (got < 3 && n < 20) begin
            if (rsp_valid) begin
                checks++;
                if (rsp_data !== (32'hA5000000 | 32'(20 + got))) begin
                    errors++;
                    $display("FAIL bp_order idx=%0d got %h want %h", got, rsp_data, 32'hA5000000 | 32'(20 + got));
                end
                $display("bp response %0d data=%h", got, rsp_data);
                got++;
            end
            @(negedge clk);
            n++;
        end
        checks++; if (got != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got); end
        repeat (2) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_extra got rsp_valid=%b want 0", rsp_valid); end
    endtask

    task automatic test_clear_drain;
        logic [31:0] d;
        bit ok;
        int got;
        int n;
        int cyc;
        do_write(6'd30, 32'h12345678, 4'hF);
        rsp_ready = 1'b0;
        issue_reads(20, 2);
        clear_req = 1'b1;
        rd_valid  = 1'b1;
        rd_addr   = 6'd22;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL clear_same_cycle_read got rd_ready=%b want 1", rd_ready); end
        @(negedge clk);
        clear_req = 1'b0;
        rd_valid  = 1'b0;
        checks++;
        if (init_done !== 1'b0 || wr_ready !== 1'b0 || rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_entry got init_done=%b wr_ready=%b rd_ready=%b want 0 0 0", init_done, wr_ready, rd_ready);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (init_done !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_hold got init_done=%b rsp_valid=%b want 0 1", init_done, rsp_valid);
        end
        rsp_ready = 1'b1;
        got = 0;
        n = 0;
        while (got < 3 && n < 20) begin
            if (rsp_valid) begin
                checks++;
                if (rsp_data !== (32'hA5000000 | 32'(20 + got))) begin
                    errors++;
                    $display("FAIL drain_data idx=%0d got %h want %h", got, rsp_data, 32'hA5000000 | 32'(20 + got));
                end
                $display("drain response %0d data=%h", got, rsp_data);
                got++;
            end
            @(negedge clk);
            n++;
        end
        checks++; if (got != 3) begin errors++; $display("FAIL drain_count got %0d want 3", got); end
        cyc = 0;
        while (!init_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (init_done !== 1'b1 || cyc < 64 || cyc > 70) begin
            errors++;
            $display("FAIL reinit got init_done=%b after %0d cycles want 1 within 64..70", init_done, cyc);
        end
        do_read(6'd30, d, ok);
        checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL cleared_30 got %h want 00000000", d); end
        do_read(6'd20, d, ok);
        checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL cleared_20 got %h want 00000000", d); end
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        bit ok;
        int n;
        int cyc;
        int stale;
        do_write(6'd40, 32'hCAFEF00D, 4'hF);
        do_write(6'd41, 32'h0BADBEEF, 4'hF);
        rsp_ready = 1'b0;
        issue_reads(40, 2);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b want 1", rsp_valid); end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL ar_immediate got valid=%b data=%h rd_ready=%b want 0 0 0", rsp_valid, rsp_data, rd_ready);
        end
        repeat (3) @(negedge clk);
        rstn      = 1'b1;
        rsp_ready = 1'b1;
        cyc   = 0;
        stale = 0;
        while (!init_done && cyc < 200) begin
            @(posedge clk);
            #1;
            if (rsp_valid) stale++;
            cyc++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL ar_stale got %0d responses want 0", stale); end
        checks++; if (cyc != 64) begin errors++; $display("FAIL ar_init_latency got %0d want 64", cyc); end
        repeat (3) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_late_stale got %b want 0", rsp_valid); end
        do_read(6'd40, d, ok);
        checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL ar_cleared got %h want 00000000", d); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_init_zero();
        test_byte_write();
        test_collision();
        test_backpressure();
        test_clear_drain();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
